// File: rtl/pipe_flow_ctrl_if.sv
// Pipeline control bundle between the flow controller and the datapath.
// The master side is the controller: it receives stall/jump/halt requests
// and drives hold/flush/redirect controls. The slave side is the datapath.
// Optional macro PIPE_FLOW_CTRL_PERF_CNT_EN adds the performance counter outputs.
interface pipe_flow_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              id_stall_req_i;
  logic              ex_stall_req_i;
  logic              mem_stall_req_i;
  logic              ex_jump_req_i;
  logic [ADDR_W-1:0] ex_jump_addr_i;
  logic              halt_req_i;
  logic              pc_hold_o;
  logic              pc_redirect_o;
  logic [ADDR_W-1:0] pc_redirect_addr_o;
  logic              if_id_hold_o;
  logic              id_ex_hold_o;
  logic              ex_mem_hold_o;
  logic              if_id_flush_o;
  logic              id_ex_flush_o;
  logic              ex_mem_flush_o;
  logic              mem_wb_flush_o;
  logic              halted_o;
`ifdef PIPE_FLOW_CTRL_PERF_CNT_EN
  logic [31:0]       stall_cycles_o;
  logic [31:0]       redirect_cnt_o;
`endif

  modport master (
    input  id_stall_req_i, ex_stall_req_i, mem_stall_req_i,
           ex_jump_req_i, ex_jump_addr_i, halt_req_i,
    output pc_hold_o, pc_redirect_o, pc_redirect_addr_o,
           if_id_hold_o, id_ex_hold_o, ex_mem_hold_o,
           if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, mem_wb_flush_o,
           halted_o
`ifdef PIPE_FLOW_CTRL_PERF_CNT_EN
          , stall_cycles_o, redirect_cnt_o
`endif
  );

  modport slave (
    output id_stall_req_i, ex_stall_req_i, mem_stall_req_i,
           ex_jump_req_i, ex_jump_addr_i, halt_req_i,
    input  pc_hold_o, pc_redirect_o, pc_redirect_addr_o,
           if_id_hold_o, id_ex_hold_o, ex_mem_hold_o,
           if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, mem_wb_flush_o,
           halted_o
`ifdef PIPE_FLOW_CTRL_PERF_CNT_EN
          , stall_cycles_o, redirect_cnt_o
`endif
  );
endinterface

// File: rtl/pipe_flow_ctrl.sv
// Central hold/flush/redirect controller for the 5-stage pipeline.
// Resolves stall priority (MEM > EX > ID), defers jumps that arrive while
// the EX instruction is frozen, and runs the debug halt/drain sequence.
// Optional macro PIPE_FLOW_CTRL_PERF_CNT_EN adds stall and redirect counters.
module pipe_flow_ctrl #(
  parameter int ADDR_W       = 32,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  pipe_flow_ctrl_if.master ctrl_if
);

  localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PEND   = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [CNT_W-1:0]  drain_cnt_q, drain_cnt_d;
  logic              halted_q, halted_d;

  logic              pcHold, pcRedirect;
  logic [ADDR_W-1:0] redirAddr;
  logic              ifIdHold, idExHold, exMemHold;
  logic              ifIdFlush, idExFlush, exMemFlush, memWbFlush;
  logic              exFrozen;

  assign exFrozen = ctrl_if.mem_stall_req_i | ctrl_if.ex_stall_req_i;

  // State, pending jump target, drain counter and halted flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      pend_addr_q <= '0;
      drain_cnt_q <= '0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_addr_q <= pend_addr_d;
      drain_cnt_q <= drain_cnt_d;
      halted_q    <= halted_d;
    end
  end

  // Stall pattern first, then state-specific redirect/drain overrides
  always_comb begin
    state_d     = state_q;
    pend_addr_d = pend_addr_q;
    drain_cnt_d = drain_cnt_q;
    halted_d    = halted_q;
    pcHold      = 1'b0;
    pcRedirect  = 1'b0;
    redirAddr   = '0;
    ifIdHold    = 1'b0;
    idExHold    = 1'b0;
    exMemHold   = 1'b0;
    ifIdFlush   = 1'b0;
    idExFlush   = 1'b0;
    exMemFlush  = 1'b0;
    memWbFlush  = 1'b0;

    if (ctrl_if.mem_stall_req_i) begin
      pcHold     = 1'b1;
      ifIdHold   = 1'b1;
      idExHold   = 1'b1;
      exMemHold  = 1'b1;
      memWbFlush = 1'b1;
    end else if (ctrl_if.ex_stall_req_i) begin
      pcHold     = 1'b1;
      ifIdHold   = 1'b1;
      idExHold   = 1'b1;
      exMemFlush = 1'b1;
    end else if (ctrl_if.id_stall_req_i) begin
      pcHold     = 1'b1;
      ifIdHold   = 1'b1;
      idExFlush  = 1'b1;
    end

    case (state_q)
      RUN: begin
        if (ctrl_if.ex_jump_req_i && exFrozen) begin
          pend_addr_d = ctrl_if.ex_jump_addr_i;
          state_d     = PEND;
        end else begin
          if (ctrl_if.ex_jump_req_i) begin
            pcRedirect = 1'b1;
            redirAddr  = ctrl_if.ex_jump_addr_i;
            pcHold     = 1'b0;
            ifIdHold   = 1'b0;
            ifIdFlush  = 1'b1;
            idExFlush  = 1'b1;
          end
          if (ctrl_if.halt_req_i) begin
            state_d = DRAIN;
          end
        end
      end
      PEND: begin
        if (!exFrozen) begin
          pcRedirect = 1'b1;
          redirAddr  = pend_addr_q;
          pcHold     = 1'b0;
          ifIdHold   = 1'b0;
          ifIdFlush  = 1'b1;
          idExFlush  = 1'b1;
          state_d    = ctrl_if.halt_req_i ? DRAIN : RUN;
        end
      end
      DRAIN: begin
        if (ctrl_if.ex_jump_req_i && !exFrozen) begin
          pcRedirect = 1'b1;
          redirAddr  = ctrl_if.ex_jump_addr_i;
          idExFlush  = 1'b1;
        end
        pcHold    = 1'b1;
        ifIdFlush = 1'b1;
        if (!ctrl_if.halt_req_i) begin
          state_d     = RUN;
          drain_cnt_d = '0;
        end else if (!exFrozen) begin
          if (drain_cnt_q == CntLast) begin
            state_d  = HALTED;
            halted_d = 1'b1;
          end else begin
            drain_cnt_d = drain_cnt_q + 1'b1;
          end
        end
      end
      HALTED: begin
        pcHold    = 1'b1;
        ifIdFlush = 1'b1;
        if (!ctrl_if.halt_req_i) begin
          state_d     = RUN;
          halted_d    = 1'b0;
          drain_cnt_d = '0;
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign ctrl_if.pc_hold_o          = pcHold;
  assign ctrl_if.pc_redirect_o      = pcRedirect;
  assign ctrl_if.pc_redirect_addr_o = redirAddr;
  assign ctrl_if.if_id_hold_o       = ifIdHold & ~ifIdFlush;
  assign ctrl_if.id_ex_hold_o       = idExHold & ~idExFlush;
  assign ctrl_if.ex_mem_hold_o      = exMemHold & ~exMemFlush;
  assign ctrl_if.if_id_flush_o      = ifIdFlush;
  assign ctrl_if.id_ex_flush_o      = idExFlush;
  assign ctrl_if.ex_mem_flush_o     = exMemFlush;
  assign ctrl_if.mem_wb_flush_o     = memWbFlush;
  assign ctrl_if.halted_o           = halted_q;

`ifdef PIPE_FLOW_CTRL_PERF_CNT_EN
  logic [31:0] stall_cycles_q, redirect_cnt_q;

  // Count frozen-PC cycles outside the halt sequence, and every redirect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      redirect_cnt_q <= '0;
    end else begin
      if (pcHold && (state_q == RUN || state_q == PEND)) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if (pcRedirect) begin
        redirect_cnt_q <= redirect_cnt_q + 32'd1;
      end
    end
  end

  assign ctrl_if.stall_cycles_o = stall_cycles_q;
  assign ctrl_if.redirect_cnt_o = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Directed self-checking bench for pipe_flow_ctrl (ADDR_W=32, DRAIN_CYCLES=4).
// Control outputs are packed {pc_hold, pc_redirect, if_id_hold, id_ex_hold,
// ex_mem_hold, if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, halted}.
module tb_pipe_flow_ctrl;

  localparam logic [9:0] VecIdle   = 10'b0000000000;
  localparam logic [9:0] VecMem    = 10'b1011100010;
  localparam logic [9:0] VecEx     = 10'b1011000100;
  localparam logic [9:0] VecId     = 10'b1010001000;
  localparam logic [9:0] VecJump   = 10'b0100011000;
  localparam logic [9:0] VecDrain  = 10'b1000010000;
  localparam logic [9:0] VecDrJmp  = 10'b1100011000;
  localparam logic [9:0] VecHalted = 10'b1000010001;

  logic clk;
  logic rst_n;
  int   checkCount;
  int   errorCount;

  pipe_flow_ctrl_if #(.ADDR_W(32)) busIf ();

  pipe_flow_ctrl #(
    .ADDR_W      (32),
    .DRAIN_CYCLES(4)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ctrl_if(busIf.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] ctrlVec();
    return {busIf.pc_hold_o, busIf.pc_redirect_o, busIf.if_id_hold_o,
            busIf.id_ex_hold_o, busIf.ex_mem_hold_o, busIf.if_id_flush_o,
            busIf.id_ex_flush_o, busIf.ex_mem_flush_o, busIf.mem_wb_flush_o,
            busIf.halted_o};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs mid-cycle, then settle before checking
  task automatic applyStimulus(input logic idS, input logic exS, input logic memS,
                               input logic jmp, input logic [31:0] addr,
                               input logic halt);
    @(negedge clk);
    busIf.id_stall_req_i  = idS;
    busIf.ex_stall_req_i  = exS;
    busIf.mem_stall_req_i = memS;
    busIf.ex_jump_req_i   = jmp;
    busIf.ex_jump_addr_i  = addr;
    busIf.halt_req_i      = halt;
    #1;
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    rst_n = 1'b0;
    busIf.id_stall_req_i  = 1'b0;
    busIf.ex_stall_req_i  = 1'b0;
    busIf.mem_stall_req_i = 1'b0;
    busIf.ex_jump_req_i   = 1'b0;
    busIf.ex_jump_addr_i  = 32'h0;
    busIf.halt_req_i      = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_outputs", 64'(ctrlVec()), 64'(VecIdle));
    checkOutput("reset_addr", 64'(busIf.pc_redirect_addr_o), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(0, 0, 0, 0, 32'h0, 0);
    checkOutput("idle_run", 64'(ctrlVec()), 64'(VecIdle));

    // Load-use stall for two cycles
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 0, 0, 0, 32'h0, 0);
      checkOutput($sformatf("id_stall_%0d", i), 64'(ctrlVec()), 64'(VecId));
    end

    // Unstalled jump redirects in the same cycle
    applyStimulus(0, 0, 0, 1, 32'h0000_0100, 0);
    checkOutput("jump_vec", 64'(ctrlVec()), 64'(VecJump));
    checkOutput("jump_addr", 64'(busIf.pc_redirect_addr_o), 64'h100);

    // Jump wins over a load-use stall
    applyStimulus(1, 0, 0, 1, 32'h0000_0180, 0);
    checkOutput("jump_over_id_vec", 64'(ctrlVec()), 64'(VecJump));
    checkOutput("jump_over_id_addr", 64'(busIf.pc_redirect_addr_o), 64'h180);

    // Jump held under a 3-cycle MEM stall: one redirect once the stall drops
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 1, 1, 32'h0000_0200, 0);
      checkOutput($sformatf("mem_jump_hold_%0d", i), 64'(ctrlVec()), 64'(VecMem));
    end
    applyStimulus(0, 0, 0, 1, 32'h0000_0200, 0);
    checkOutput("mem_jump_release_vec", 64'(ctrlVec()), 64'(VecJump));
    checkOutput("mem_jump_release_addr", 64'(busIf.pc_redirect_addr_o), 64'h200);
    applyStimulus(0, 0, 0, 0, 32'h0, 0);
    checkOutput("mem_jump_once", 64'(ctrlVec()), 64'(VecIdle));

    // Pending target comes from the latched address, not the live bus
    applyStimulus(0, 1, 0, 1, 32'h0000_0300, 0);
    checkOutput("ex_jump_hold", 64'(ctrlVec()), 64'(VecEx));
    applyStimulus(0, 0, 0, 0, 32'h0000_0BAD, 0);
    checkOutput("ex_jump_release_vec", 64'(ctrlVec()), 64'(VecJump));
    checkOutput("ex_jump_release_addr", 64'(busIf.pc_redirect_addr_o), 64'h300);

    // Priority: MEM over ID, EX over ID
    applyStimulus(1, 0, 1, 0, 32'h0, 0);
    checkOutput("mem_over_id", 64'(ctrlVec()), 64'(VecMem));
    applyStimulus(1, 1, 0, 0, 32'h0, 0);
    checkOutput("ex_over_id", 64'(ctrlVec()), 64'(VecEx));
    applyStimulus(0, 1, 1, 0, 32'h0, 0);
    checkOutput("mem_over_ex", 64'(ctrlVec()), 64'(VecMem));

    // Halt with one EX stall inside the drain: five DRAIN cycles, then HALTED
    applyStimulus(0, 0, 0, 0, 32'h0, 1);
    checkOutput("halt_run_cycle", 64'(ctrlVec()), 64'(VecIdle));
    applyStimulus(0, 0, 0, 0, 32'h0, 1);
    checkOutput("drain_1", 64'(ctrlVec()), 64'(VecDrain));
    applyStimulus(0, 1, 0, 0, 32'h0, 1);
    checkOutput("drain_stall_pc_hold", 64'(busIf.pc_hold_o), 64'h1);
    checkOutput("drain_stall_if_flush", 64'(busIf.if_id_flush_o), 64'h1);
    checkOutput("drain_stall_halted", 64'(busIf.halted_o), 64'h0);
    for (int i = 3; i <= 5; i++) begin
      applyStimulus(0, 0, 0, 0, 32'h0, 1);
      checkOutput($sformatf("drain_%0d", i), 64'(ctrlVec()), 64'(VecDrain));
    end
    applyStimulus(0, 0, 0, 0, 32'h0, 1);
    checkOutput("halted_a", 64'(ctrlVec()), 64'(VecHalted));
    applyStimulus(0, 0, 0, 0, 32'h0, 0);
    checkOutput("halted_release_cycle", 64'(ctrlVec()), 64'(VecHalted));
    applyStimulus(0, 0, 0, 0, 32'h0, 0);
    checkOutput("after_halt_run", 64'(ctrlVec()), 64'(VecIdle));

    // Abort drain, then a fresh halt must count all four cycles again
    applyStimulus(0, 0, 0, 0, 32'h0, 1);
    applyStimulus(0, 0, 0, 0, 32'h0, 1);
    applyStimulus(0, 0, 0, 0, 32'h0, 1);
    applyStimulus(0, 0, 0, 0, 32'h0, 0);
    checkOutput("abort_cycle", 64'(ctrlVec()), 64'(VecDrain));
    applyStimulus(0, 0, 0, 0, 32'h0, 1);
    checkOutput("abort_back_run", 64'(ctrlVec()), 64'(VecIdle));
    // Jump during the first drain cycle still redirects and is still counted
    applyStimulus(0, 0, 0, 1, 32'h0000_0400, 1);
    checkOutput("drain_jump_vec", 64'(ctrlVec()), 64'(VecDrJmp));
    checkOutput("drain_jump_addr", 64'(busIf.pc_redirect_addr_o), 64'h400);
    for (int i = 2; i <= 4; i++) begin
      applyStimulus(0, 0, 0, 0, 32'h0, 1);
      checkOutput($sformatf("redrain_%0d", i), 64'(ctrlVec()), 64'(VecDrain));
    end
    applyStimulus(0, 0, 0, 0, 32'h0, 1);
    checkOutput("halted_b", 64'(ctrlVec()), 64'(VecHalted));
    applyStimulus(0, 0, 0, 0, 32'h0, 0);
    applyStimulus(0, 0, 0, 0, 32'h0, 0);
    checkOutput("after_halt_b", 64'(ctrlVec()), 64'(VecIdle));

    // Halt arriving in PEND waits for the redirect, then drains
    applyStimulus(0, 0, 1, 1, 32'h0000_0500, 1);
    checkOutput("pend_halt_hold", 64'(ctrlVec()), 64'(VecMem));
    applyStimulus(0, 0, 0, 1, 32'h0000_0500, 1);
    checkOutput("pend_halt_redirect", 64'(ctrlVec()), 64'(VecJump));
    checkOutput("pend_halt_addr", 64'(busIf.pc_redirect_addr_o), 64'h500);
    applyStimulus(0, 0, 0, 0, 32'h0, 1);
    checkOutput("pend_halt_drain", 64'(ctrlVec()), 64'(VecDrain));
    applyStimulus(0, 0, 0, 0, 32'h0, 0);
    applyStimulus(0, 0, 0, 0, 32'h0, 0);
    checkOutput("pend_halt_back_run", 64'(ctrlVec()), 64'(VecIdle));

    // Reset while a jump to 0x300 is pending discards it
    applyStimulus(0, 0, 1, 1, 32'h0000_0300, 0);
    checkOutput("pend_before_reset", 64'(ctrlVec()), 64'(VecMem));
    @(negedge clk);
    busIf.mem_stall_req_i = 1'b0;
    busIf.ex_jump_req_i   = 1'b0;
    busIf.ex_jump_addr_i  = 32'h0;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_mid_vec", 64'(ctrlVec()), 64'(VecIdle));
    checkOutput("reset_mid_addr", 64'(busIf.pc_redirect_addr_o), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, 0, 0, 32'h0, 0);
      checkOutput($sformatf("post_reset_%0d", i), 64'(ctrlVec()), 64'(VecIdle));
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
